// File: rtl/pc_sequencer_if.sv
// Request/status bundle between an instruction fetch controller and pc_sequencer.
// Requests are level inputs, sampled every rising clock edge. All status outputs are registered.
// There is no backpressure: every request is either acted on or ignored in the cycle it is presented.
interface pc_sequencer_if #(
    parameter int ADDR_WIDTH = 6
);
    logic                  pc_load;
    logic [7:0]            opcode;
    logic                  jump_en;
    logic                  call_en;
    logic                  ret_en;
    logic [ADDR_WIDTH-1:0] jump_addr;
    logic                  halt_req;
    logic                  resume;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  halted;
    logic                  fault;
    logic                  stack_empty;
    logic                  stack_full;
    logic                  wrap;

    modport master (
        output pc_load, opcode, jump_en, call_en, ret_en, jump_addr, halt_req, resume,
        input  pc, halted, fault, stack_empty, stack_full, wrap
    );

    modport slave (
        input  pc_load, opcode, jump_en, call_en, ret_en, jump_addr, halt_req, resume,
        output pc, halted, fault, stack_empty, stack_full, wrap
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer with opcode-sized advance, jump, call/ret stack and a RUN/HALT/FAULT FSM.
// Latency: one cycle. A request seen at an edge is reflected in pc and the status flags after that edge.
// No backpressure: the highest-priority request wins each cycle; stack misuse latches FAULT until reset.
module pc_sequencer #(
    parameter int ADDR_WIDTH  = 6,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_ADDR  = 0
) (
    input  logic            clock,
    input  logic            reset,
    pc_sequencer_if.slave   bus
);
    localparam int CW  = $clog2(STACK_DEPTH + 1);
    localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int AW1 = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_FAULT} state_t;

    state_t                state_q, state_nxt;
    logic [ADDR_WIDTH-1:0] pc_q, pc_nxt;
    logic [CW-1:0]         occ_q, occ_nxt;
    logic                  wrap_q, wrap_nxt;
    logic                  push;
    logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic [AW1-1:0]        seq_sum;
    logic [IW-1:0]         wr_idx, rd_idx;

    function automatic logic [1:0] instr_size(input logic [7:0] op);
        case (op)
            8'h78, 8'h80, 8'h81, 8'h82, 8'h84, 8'h85, 8'h87: return 2'd2;
            8'h83:                                            return 2'd1;
            default:                                          return 2'd3;
        endcase
    endfunction

    // The extra top bit of the sum is the wrap indication; the low bits are also the call return address.
    assign seq_sum = {1'b0, pc_q} + AW1'(instr_size(bus.opcode));
    assign wr_idx  = IW'(occ_q);
    assign rd_idx  = IW'(occ_q - CW'(1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_RUN;
            pc_q    <= ADDR_WIDTH'(RESET_ADDR);
            occ_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            pc_q    <= pc_nxt;
            occ_q   <= occ_nxt;
            wrap_q  <= wrap_nxt;
        end
    end

    // Storage is not reset; entries above the occupancy count are never read.
    always_ff @(posedge clock) begin
        if (reset && push)
            stack_mem[wr_idx] <= seq_sum[ADDR_WIDTH-1:0];
    end

    always_comb begin
        state_nxt = state_q;
        pc_nxt    = pc_q;
        occ_nxt   = occ_q;
        wrap_nxt  = 1'b0;
        push      = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.halt_req) begin
                    state_nxt = ST_HALT;
                end else if (bus.ret_en) begin
                    if (occ_q == '0) begin
                        state_nxt = ST_FAULT;
                    end else begin
                        pc_nxt  = stack_mem[rd_idx];
                        occ_nxt = occ_q - CW'(1);
                    end
                end else if (bus.call_en) begin
                    if (occ_q == CW'(STACK_DEPTH)) begin
                        state_nxt = ST_FAULT;
                    end else begin
                        push    = 1'b1;
                        pc_nxt  = bus.jump_addr;
                        occ_nxt = occ_q + CW'(1);
                    end
                end else if (bus.jump_en) begin
                    pc_nxt = bus.jump_addr;
                end else if (bus.pc_load) begin
                    pc_nxt   = seq_sum[ADDR_WIDTH-1:0];
                    wrap_nxt = seq_sum[ADDR_WIDTH];
                end
            end
            ST_HALT: begin
                if (bus.resume)
                    state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_FAULT;
            end
        endcase
    end

    assign bus.pc          = pc_q;
    assign bus.halted      = (state_q == ST_HALT);
    assign bus.fault       = (state_q == ST_FAULT);
    assign bus.stack_empty = (occ_q == '0);
    assign bus.stack_full  = (occ_q == CW'(STACK_DEPTH));
    assign bus.wrap        = wrap_q;
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 6, SHALL set the program-counter and address width.
REQ-002 Parameter STACK_DEPTH, default 4, SHALL set the return-address stack depth (legal range 1..16).
REQ-003 Parameter RESET_ADDR, default 0, SHALL set the pc value loaded at reset.
REQ-004 clock  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-005 reset  input  1  SHALL be the synchronous, active-low reset.
REQ-006 pc_load  input  1  SHALL request a sequential advance by the current instruction size.
REQ-007 opcode  input  8  SHALL be the current opcode used for instruction sizing.
REQ-008 jump_en  input  1  SHALL request an unconditional load of jump_addr.
REQ-009 call_en  input  1  SHALL request push of the return address plus a load of jump_addr.
REQ-010 ret_en  input  1  SHALL request a pop of the stack top into pc.
REQ-011 jump_addr  input  ADDR_WIDTH  SHALL be the target for jump and call.
REQ-012 halt_req  input  1  SHALL request entry to HALT.
REQ-013 resume  input  1  SHALL request return from HALT to RUN.
REQ-014 pc  output  ADDR_WIDTH  SHALL be the registered program counter.
REQ-015 halted  output  1  SHALL be high only in state HALT.
REQ-016 fault  output  1  SHALL be high only in state FAULT.
REQ-017 stack_empty / stack_full  output  1 each  SHALL reflect stack occupancy of 0 / STACK_DEPTH.
REQ-018 wrap  output  1  SHALL pulse for one cycle when a sequential advance wraps past 2^ADDR_WIDTH-1.

Function
REQ-019 Instruction size SHALL be 2 for opcodes 0x78, 0x80, 0x81, 0x82, 0x84, 0x85, 0x87; 1 for 0x83; 3 for all others.
REQ-020 Sequential advance SHALL be pc <= (pc + size) mod 2^ADDR_WIDTH; wrap SHALL be asserted the following cycle iff the unsized sum is at least 2^ADDR_WIDTH.
REQ-021 The FSM SHALL have states RUN, HALT and FAULT; reset SHALL enter RUN.
REQ-022 In RUN, the request priority SHALL be halt_req > ret_en > call_en > jump_en > pc_load; exactly one action SHALL occur per cycle.
REQ-023 RUN with halt_req: the next state SHALL be HALT, pc SHALL be held, and every other request in that cycle SHALL be ignored.
REQ-024 HALT: pc and the stack SHALL be frozen; resume SHALL return to RUN on the next edge; other requests SHALL be ignored.
REQ-025 Call: the stack SHALL push pc + size(opcode) (mod 2^ADDR_WIDTH) and pc SHALL take jump_addr in the same cycle.
REQ-026 Ret: pc SHALL take the stack top and occupancy SHALL decrement in the same cycle.
REQ-027 Jump: pc SHALL take jump_addr with the stack unchanged.
REQ-028 A call with the stack full, or a ret with the stack empty, SHALL enter FAULT with pc and the stack unchanged.
REQ-029 FAULT SHALL be left only by reset; all requests SHALL be ignored and pc held.
REQ-030 With no request active, pc and the stack SHALL hold.

Reset
REQ-031 On a rising clock edge with reset low: pc SHALL equal RESET_ADDR, occupancy SHALL be 0, and state SHALL be RUN.
REQ-032 After reset: halted=0, fault=0, wrap=0, stack_empty=1, stack_full=0.
REQ-033 Reset SHALL override every request, including reset asserted mid-HALT or in FAULT.
REQ-034 Stack storage contents need not be cleared; they SHALL be unobservable while empty.

Verification
REQ-035 Sizing: reset, then pc_load with opcodes 0x78, 0x83, 0x00 on consecutive cycles -> pc = 0, 2, 3, 6.
REQ-036 Wrap: pc=62, opcode 0x00, pc_load -> pc=1 and wrap=1 for one cycle.
REQ-037 Call/ret: pc=4, opcode 0x80, call_en, jump_addr=40 -> pc=40 and stack_empty=0; then ret_en -> pc=6 and stack_empty=1.
REQ-038 Overflow: four calls with STACK_DEPTH=4 -> stack_full=1; a fifth call -> fault=1 and pc unchanged; pc_load and resume ignored until reset.
REQ-039 Priority/halt: halt_req with call_en and pc_load in the same cycle -> halted=1, pc unchanged, stack unchanged; resume -> halted=0 the next cycle.
REQ-040 Reset mid-operation: reset low while in HALT with occupancy 2 -> pc=RESET_ADDR, stack_empty=1, halted=0 the next cycle.
